// File: rtl/mem_load_aligner.sv
// Load aligner: issues one or two word-aligned reads for a byte-addressed load,
// merges the returned words, right-aligns the bytes and zero/sign-extends to N bits.
module mem_load_aligner #(
   parameter int N  = 64,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [2:0]    req_width,
   input  logic          req_signed,
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic [AW-1:0] mem_req_addr,
   input  logic          mem_rsp_valid,
   input  logic [N-1:0]  mem_rsp_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_err,
   output logic          rsp_split
);

   localparam int B  = N / 8;
   localparam int OW = $clog2(B);

   typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

   state_t state_reg, state_next;

   logic [AW-1:0] addr_reg;
   logic [2:0]    width_reg;
   logic          signed_reg;
   logic          err_reg;
   logic          split_reg;
   logic [N-1:0]  lo_reg;
   logic [N-1:0]  hi_reg;

   logic          accept;
   logic          req_legal;
   logic [OW-1:0] req_off;
   logic [4:0]    req_end;
   logic          req_split;

   assign accept    = (state_reg == IDLE) && req_valid;
   assign req_legal = (req_width == 3'b000) || (req_width == 3'b001) ||
                      (req_width == 3'b011) || ((req_width == 3'b111) && (N == 64));
   assign req_off   = req_addr[OW-1:0];
   assign req_end   = 5'(req_off) + 5'(req_width) + 5'd1;
   assign req_split = req_end > 5'(B);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Request fields are captured once; lo/hi are cleared so an unsplit access merges with zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_reg   <= '0;
         width_reg  <= '0;
         signed_reg <= 1'b0;
         err_reg    <= 1'b0;
         split_reg  <= 1'b0;
         lo_reg     <= '0;
         hi_reg     <= '0;
      end else begin
         if (accept) begin
            addr_reg   <= req_addr;
            width_reg  <= req_width;
            signed_reg <= req_signed;
            err_reg    <= !req_legal;
            split_reg  <= req_legal && req_split;
            lo_reg     <= '0;
            hi_reg     <= '0;
         end
         if ((state_reg == WAIT1) && mem_rsp_valid) begin
            lo_reg <= mem_rsp_data;
         end
         if ((state_reg == WAIT2) && mem_rsp_valid) begin
            hi_reg <= mem_rsp_data;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid)     state_next = req_legal ? REQ1 : RESP;
         REQ1:    if (mem_req_ready) state_next = WAIT1;
         WAIT1:   if (mem_rsp_valid) state_next = split_reg ? REQ2 : RESP;
         REQ2:    if (mem_req_ready) state_next = WAIT2;
         WAIT2:   if (mem_rsp_valid) state_next = RESP;
         RESP:    if (rsp_ready)     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   logic [AW-1:0]  base_addr;
   logic [2*N-1:0] merged;
   logic [2*N-1:0] merged_shift;
   logic [OW+2:0]  shamt;
   logic [N-1:0]   shifted;
   logic [N-1:0]   ext_data;
   logic [3:0]     nb;
   logic           sbit;
   logic           fill;

   assign base_addr    = {addr_reg[AW-1:OW], {OW{1'b0}}};
   assign merged       = {hi_reg, lo_reg};
   assign shamt        = {addr_reg[OW-1:0], 3'b000};
   assign merged_shift = merged >> shamt;
   assign shifted      = merged_shift[N-1:0];
   assign nb           = {1'b0, width_reg} + 4'd1;

   always_comb begin
      case (width_reg)
         3'b000:  sbit = shifted[7];
         3'b001:  sbit = shifted[15];
         3'b011:  sbit = shifted[31];
         default: sbit = shifted[N-1];
      endcase
   end

   assign fill = signed_reg & sbit;

   // Bytes inside the access pass through; bytes above it take the extension fill.
   genvar gi;
   generate
      for (gi = 0; gi < B; gi = gi + 1) begin : g_byte
         localparam logic [3:0] BIDX = 4'(gi);
         assign ext_data[gi*8 +: 8] = (BIDX < nb) ? shifted[gi*8 +: 8] : {8{fill}};
      end
   endgenerate

   always_comb begin
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      rsp_valid     = 1'b0;
      rsp_data      = '0;
      rsp_err       = 1'b0;
      rsp_split     = 1'b0;
      case (state_reg)
         IDLE: req_ready = 1'b1;
         REQ1: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = base_addr;
         end
         REQ2: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = base_addr + AW'(B);
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_reg;
            rsp_split = split_reg;
            rsp_data  = err_reg ? '0 : ext_data;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_load_aligner.md
# mem_load_aligner

Sequential load-alignment unit between the pipeline's memory stage and a word-wide data memory port. It accepts one load request with a byte address, width code and signedness, and issues one or two aligned memory reads. A misaligned access that crosses an N-bit word boundary gets two reads. The unit then merges the bytes, right-aligns them, and zero- or sign-extends the result to N bits. It generalises the combinational read mask by adding boundary-crossing support, a request/response handshake and a configurable data width.

## Interface
- N, 64, data width in bits; legal values 32 and 64; B = N/8 bytes per memory word, OW = log2(B)
- AW, 32, byte-address width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  AW  byte address
- req_width  in  3  width code: 000 byte, 001 half, 011 word, 111 double
- req_signed  in  1  1 = sign-extend, 0 = zero-extend
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  word-aligned address (low OW bits zero)
- mem_rsp_valid  in  1  read data valid, one pulse per accepted request
- mem_rsp_data  in  N  read data
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  N  aligned, masked, extended result
- rsp_err  out  1  illegal width code (qualified by rsp_valid)
- rsp_split  out  1  access required two reads (qualified by rsp_valid)

## Operation
- Byte count is nb = req_width + 1. A width code is legal if it is 000, 001 or 011, or if it is 111 and N = 64. All other codes are illegal.
- Offset is off = req_addr[OW-1:0]. The access is split when off + nb > B. There is no alignment trap.
- All request fields are registered on acceptance; inputs are ignored outside IDLE.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
  - IDLE: req_ready = 1. On req_valid, go to RESP if the width is illegal, otherwise go to REQ1.
  - REQ1: mem_req_valid = 1, mem_req_addr = addr with the low OW bits cleared. On mem_req_ready, go to WAIT1.
  - WAIT1: on mem_rsp_valid, capture lo = mem_rsp_data. Go to REQ2 if split, otherwise go to RESP.
  - REQ2: mem_req_valid = 1, mem_req_addr = aligned addr + B, wrapping modulo 2^AW. On mem_req_ready, go to WAIT2.
  - WAIT2: on mem_rsp_valid, capture hi = mem_rsp_data, then go to RESP.
  - RESP: rsp_valid = 1. Outputs stay stable until rsp_ready, then go to IDLE.
- Merge: shifted = {hi, lo} >> (off*8), taking the low N bits. hi reads as 0 when the access is not split.
- Extension:
  - Unsigned: shifted AND mask, where the mask has nb*8 low ones.
  - Signed: bit nb*8-1 of shifted is replicated into all higher bits.
  - Double on N = 64 passes through unchanged.
- Illegal width: no memory request is issued. rsp_err = 1, rsp_data = 0, rsp_split = 0.
- mem_rsp_valid outside WAIT1/WAIT2 is ignored.

## Timing
- Reset (asynchronous, any state) goes to IDLE. Outputs during reset:
  - req_ready = 1
  - mem_req_valid = 0, mem_req_addr = 0
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, rsp_split = 0
- Reset during REQ*/WAIT* abandons the access. A late mem_rsp_valid after reset is ignored.
- Only one access is outstanding at a time. req_ready is 0 from the cycle after acceptance until the cycle after the rsp_valid/rsp_ready handshake. There is no back-to-back overlap.
- All outputs are registered or decoded from state. There is no combinational path from req_* to mem_req_* or from mem_rsp_* to rsp_*.
- mem_req_valid, once high, holds with a stable address until mem_req_ready. Memory responds no earlier than the cycle after the request handshake.
- Latency with a ready memory that responds one cycle after acceptance, counted from the acceptance edge to the first rsp_valid cycle:
  - 3 cycles for an aligned or non-split access
  - 5 cycles for a split access
  - 1 cycle for an illegal width
- rsp_valid held under rsp_ready = 0 keeps rsp_data, rsp_err and rsp_split constant.

## Test plan
- Memory model, N = 64: word at 0x0 = 0x8877665544332211, word at 0x8 = 0xFFEEDDCCBBAA9999. Zero-wait memory and rsp_ready = 1 unless stated.
- Signed byte at 0x7 -> rsp_data = 0xFFFFFFFFFFFFFF88, rsp_split = 0, one mem_req at 0x0. The same access unsigned -> 0x0000000000000088.
- Unsigned word at 0x6 -> mem_req at 0x0 then at 0x8, rsp_data = 0x0000000099998877, rsp_split = 1, rsp_valid 5 cycles after acceptance.
- Double at 0x3 -> rsp_data = 0xAA99998877665544, rsp_split = 1. Signed half at 0x2 -> 0x0000000000004433, not split.
- req_width = 010 -> no mem_req_valid, rsp_valid the next cycle with rsp_err = 1 and rsp_data = 0. Same result for 111 with N = 32.
- Backpressure:
  - mem_req_ready low for 3 cycles -> address stable and no state advance.
  - rsp_ready low for 4 cycles -> outputs stable and req_ready = 0.
  - mem_rsp_valid pulsed in IDLE -> ignored.
- reset_n asserted during WAIT2 of a split load -> all outputs go to reset values immediately. The stale mem_rsp_valid is ignored. The next aligned load completes correctly.
